// File: rtl/reset_pkg.sv
// Shared types for the reset request generator: FSM states and reset causes.
package reset_pkg;

   localparam int unsigned CAUSE_W = 3;
   localparam int unsigned PHASE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_NONE = 3'd0,
      CAUSE_BTN  = 3'd1,
      CAUSE_SW   = 3'd2,
      CAUSE_WDT  = 3'd3,
      CAUSE_LOCK = 3'd4
   } cause_t;

   // A zero-length pulse still has to be visible for one cycle.
   function automatic logic [PHASE_W-1:0] at_least_one(input logic [PHASE_W-1:0] v);
      return (v == '0) ? PHASE_W'(1) : v;
   endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus debouncer for an active-low push button.
// Emits a one-cycle press strobe when the input has been low long enough.
module debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic din_n,
   output logic press
);

   localparam logic [15:0] LIMIT = (DEBOUNCE_CYCLES == 16'd0) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;

   logic        meta;
   logic        sync;
   logic        stable;
   logic [15:0] count;

   // Synchronizer flops reset to the released (high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= din_n;
         sync <= meta;
      end
   end

   // Accept a level change only after it has persisted for the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= 1'b1;
         count  <= 16'd0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync == stable) begin
            count <= 16'd0;
         end else if (count == LIMIT) begin
            stable <= sync;
            count  <= 16'd0;
            press  <= ~sync;
         end else begin
            count <= count + 16'd1;
         end
      end
   end

endmodule

// File: rtl/reset_request_gen.sv
// Collects button, software, watchdog and PLL-lock events and turns the
// highest-priority one into a fixed-width active-low reset request pulse,
// followed by a holdoff window in which further events are dropped.
module reset_request_gen
   import reset_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] WDT_CYCLES      = 32'd100000000,
   parameter logic [7:0]  PULSE_CYCLES    = 8'd16,
   parameter logic [7:0]  HOLDOFF_CYCLES  = 8'd64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_n,
   input  logic               sw_rst_req,
   input  logic               wdt_en,
   input  logic               wdt_kick,
   input  logic               locked,
   output logic               rstn_req,
   output logic [CAUSE_W-1:0] rst_cause,
   output logic               busy
);

   localparam logic [PHASE_W-1:0] PULSE_LAST = at_least_one(PULSE_CYCLES) - PHASE_W'(1);
   localparam logic [PHASE_W-1:0] HOLD_LAST  = HOLDOFF_CYCLES - PHASE_W'(1);

   state_t             state;
   state_t             state_next;
   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] phase_next;
   cause_t             cause_q;
   cause_t             cause_next;
   cause_t             evt_cause;
   logic               evt_any;
   logic               rstn_next;
   logic               busy_next;

   logic               btn_evt;
   logic               lock_meta;
   logic               lock_sync;
   logic               lock_prev;
   logic               lock_evt;
   logic [31:0]        wdt_count;
   logic               wdt_evt;

   debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .din_n (btn_n),
      .press (btn_evt)
   );

   // Lock synchronizer and edge history, all resetting to "locked".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta <= 1'b1;
         lock_sync <= 1'b1;
         lock_prev <= 1'b1;
      end else begin
         lock_meta <= locked;
         lock_sync <= lock_meta;
         lock_prev <= lock_sync;
      end
   end

   assign lock_evt = lock_prev & ~lock_sync;

   // Watchdog: counts only while enabled, unkicked and idle; strobes on expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_count <= 32'd0;
         wdt_evt   <= 1'b0;
      end else begin
         wdt_evt <= 1'b0;
         if (!wdt_en || wdt_kick || (state != ST_IDLE)) begin
            wdt_count <= 32'd0;
         end else if (wdt_count == WDT_CYCLES - 32'd1) begin
            wdt_count <= 32'd0;
            wdt_evt   <= 1'b1;
         end else begin
            wdt_count <= wdt_count + 32'd1;
         end
      end
   end

   // Priority encode the event sources.
   always_comb begin
      evt_cause = CAUSE_NONE;
      if (btn_evt)         evt_cause = CAUSE_BTN;
      else if (sw_rst_req) evt_cause = CAUSE_SW;
      else if (wdt_evt)    evt_cause = CAUSE_WDT;
      else if (lock_evt)   evt_cause = CAUSE_LOCK;
      evt_any = (evt_cause != CAUSE_NONE);
   end

   // State register, phase counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         phase    <= '0;
         cause_q  <= CAUSE_NONE;
         rstn_req <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         phase    <= phase_next;
         cause_q  <= cause_next;
         rstn_req <= rstn_next;
         busy     <= busy_next;
      end
   end

   // Next-state logic: IDLE -> ASSERT -> HOLDOFF (optional) -> IDLE.
   always_comb begin
      state_next = state;
      phase_next = phase;
      case (state)
         ST_IDLE: begin
            if (evt_any) begin
               state_next = ST_ASSERT;
               phase_next = '0;
            end
         end
         ST_ASSERT: begin
            if (phase == PULSE_LAST) begin
               phase_next = '0;
               state_next = (HOLDOFF_CYCLES == 8'd0) ? ST_IDLE : ST_HOLDOFF;
            end else begin
               phase_next = phase + PHASE_W'(1);
            end
         end
         ST_HOLDOFF: begin
            if (phase == HOLD_LAST) begin
               phase_next = '0;
               state_next = ST_IDLE;
            end else begin
               phase_next = phase + PHASE_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            phase_next = '0;
         end
      endcase
   end

   // Output decode from the upcoming state; cause latches only on acceptance.
   always_comb begin
      rstn_next  = (state_next != ST_ASSERT);
      busy_next  = (state_next != ST_IDLE);
      cause_next = cause_q;
      if ((state == ST_IDLE) && evt_any) cause_next = evt_cause;
   end

   assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed bench for reset_request_gen with small timing parameters.
module tb_reset_request_gen;

   logic       clk;
   logic       rst;
   logic       btn_n;
   logic       sw_rst_req;
   logic       wdt_en;
   logic       wdt_kick;
   logic       locked;
   logic       rstn_req;
   logic [2:0] rst_cause;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int falls = 0;

   reset_request_gen #(
      .DEBOUNCE_CYCLES (16'd4),
      .WDT_CYCLES      (32'd16),
      .PULSE_CYCLES    (8'd8),
      .HOLDOFF_CYCLES  (8'd4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n),
      .sw_rst_req (sw_rst_req),
      .wdt_en     (wdt_en),
      .wdt_kick   (wdt_kick),
      .locked     (locked),
      .rstn_req   (rstn_req),
      .rst_cause  (rst_cause),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every 1->0 edge of rstn_req is the start of a request pulse.
   always @(negedge rstn_req) falls++;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_n = 1'b1; sw_rst_req = 1'b0;
      wdt_en = 1'b0; wdt_kick = 1'b0; locked = 1'b1;
      repeat (3) tick();
      total++; if (rstn_req !== 1'b1) begin bad++; $display("FAIL reset_rstn: got %b want 1", rstn_req); end
      total++; if (rst_cause !== 3'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", rst_cause); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      repeat (6) tick();
      total++; if (rstn_req !== 1'b1 || busy !== 1'b0 || rst_cause !== 3'd0) begin
         bad++; $display("FAIL post_release: rstn=%b busy=%b cause=%0d want 1 0 0", rstn_req, busy, rst_cause);
      end
   endtask

   task automatic test_sw();
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         total++; if (rstn_req !== ((i <= 8) ? 1'b0 : 1'b1)) begin
            bad++; $display("FAIL sw_rstn cycle N+%0d: got %b want %b", i, rstn_req, (i <= 8) ? 1'b0 : 1'b1);
         end
         total++; if (busy !== ((i <= 12) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL sw_busy cycle N+%0d: got %b want %b", i, busy, (i <= 12) ? 1'b1 : 1'b0);
         end
         tick();
      end
      total++; if (rst_cause !== 3'd2) begin bad++; $display("FAIL sw_cause: got %0d want 2", rst_cause); end
      repeat (3) tick();
   endtask

   task automatic test_button();
      int f0;
      f0 = falls;
      for (int g = 0; g < 2; g++) begin
         btn_n = 1'b0; repeat (2) tick();
         btn_n = 1'b1; repeat (6) tick();
      end
      btn_n = 1'b0; repeat (10) tick();
      btn_n = 1'b1; repeat (30) tick();
      total++; if (falls - f0 !== 1) begin bad++; $display("FAIL btn_pulses: got %0d want 1", falls - f0); end
      total++; if (rst_cause !== 3'd1) begin bad++; $display("FAIL btn_cause: got %0d want 1", rst_cause); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL btn_idle_busy: got %b want 0", busy); end
      f0 = falls;
      btn_n = 1'b0; repeat (3) tick();
      btn_n = 1'b1; repeat (30) tick();
      total++; if (falls - f0 !== 0) begin bad++; $display("FAIL btn_glitch_pulses: got %0d want 0", falls - f0); end
      total++; if (rst_cause !== 3'd1) begin bad++; $display("FAIL btn_glitch_cause: got %0d want 1", rst_cause); end
   endtask

   task automatic test_watchdog();
      int f0;
      wdt_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         total++; if (rstn_req !== 1'b1) begin bad++; $display("FAIL wdt_early cycle E+%0d: got %b want 1", i, rstn_req); end
      end
      tick();
      total++; if (rstn_req !== 1'b0) begin bad++; $display("FAIL wdt_pulse_start E+17: got %b want 0", rstn_req); end
      wdt_en = 1'b0;
      total++; if (rst_cause !== 3'd3) begin bad++; $display("FAIL wdt_cause: got %0d want 3", rst_cause); end
      repeat (20) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wdt_idle_busy: got %b want 0", busy); end
      f0 = falls;
      wdt_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         wdt_kick = (i % 10 == 0) ? 1'b1 : 1'b0;
         tick();
      end
      wdt_kick = 1'b0;
      wdt_en = 1'b0;
      total++; if (falls - f0 !== 0) begin bad++; $display("FAIL wdt_kicked_pulses: got %0d want 0", falls - f0); end
      total++; if (rst_cause !== 3'd3) begin bad++; $display("FAIL wdt_kicked_cause: got %0d want 3", rst_cause); end
      repeat (3) tick();
   endtask

   task automatic test_coincident();
      int f0;
      btn_n = 1'b0;
      repeat (6) tick();
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      total++; if (rstn_req !== 1'b0) begin bad++; $display("FAIL coinc_rstn: got %b want 0", rstn_req); end
      total++; if (rst_cause !== 3'd1) begin bad++; $display("FAIL coinc_cause: got %0d want 1", rst_cause); end
      f0 = falls;
      repeat (4) tick();
      btn_n = 1'b1;
      repeat (30) tick();
      total++; if (falls - f0 !== 0) begin bad++; $display("FAIL coinc_extra_pulses: got %0d want 0", falls - f0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL coinc_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_holdoff_drop();
      int f0;
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      repeat (9) tick();
      total++; if (busy !== 1'b1 || rstn_req !== 1'b1) begin
         bad++; $display("FAIL holdoff_state: busy=%b rstn=%b want 1 1", busy, rstn_req);
      end
      f0 = falls;
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      repeat (30) tick();
      total++; if (falls - f0 !== 0) begin bad++; $display("FAIL holdoff_pulses: got %0d want 0", falls - f0); end
      total++; if (rst_cause !== 3'd2) begin bad++; $display("FAIL holdoff_cause: got %0d want 2", rst_cause); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL holdoff_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_lock_and_reset();
      int f0;
      int waited;
      locked = 1'b0;
      waited = 0;
      while (rstn_req !== 1'b0 && waited < 10) begin
         tick();
         waited++;
      end
      total++; if (rstn_req !== 1'b0) begin bad++; $display("FAIL lock_pulse: got %b want 0 within 10 cycles", rstn_req); end
      total++; if (rst_cause !== 3'd4) begin bad++; $display("FAIL lock_cause: got %0d want 4", rst_cause); end
      repeat (2) tick();
      rst = 1'b1;
      #1;
      total++; if (rstn_req !== 1'b1) begin bad++; $display("FAIL midpulse_rstn: got %b want 1", rstn_req); end
      total++; if (rst_cause !== 3'd0) begin bad++; $display("FAIL midpulse_cause: got %0d want 0", rst_cause); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midpulse_busy: got %b want 0", busy); end
      locked = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      f0 = falls;
      repeat (30) tick();
      total++; if (falls - f0 !== 0) begin bad++; $display("FAIL after_reset_pulses: got %0d want 0", falls - f0); end
      total++; if (rstn_req !== 1'b1 || busy !== 1'b0 || rst_cause !== 3'd0) begin
         bad++; $display("FAIL after_reset_state: rstn=%b busy=%b cause=%0d want 1 0 0", rstn_req, busy, rst_cause);
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_button();
      test_watchdog();
      test_coincident();
      test_holdoff_drop();
      test_lock_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reset_request_gen.md
RESET_REQUEST_GEN -- requirements
Module: reset_request_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000: cycles btn_n must stay stable before a press is accepted.
REQ-002 SHALL have parameter WDT_CYCLES, default 32'd100000000: cycles without a kick before a watchdog event.
REQ-003 SHALL have parameter PULSE_CYCLES, default 8'd16: width of the rstn_req low pulse.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 8'd64: cycles after a pulse during which new events are dropped.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port btn_n, input, 1 bit: raw asynchronous push button, active-low.
REQ-008 SHALL have port sw_rst_req, input, 1 bit: synchronous software reset request, level-sampled each cycle.
REQ-009 SHALL have port wdt_en, input, 1 bit: watchdog enable.
REQ-010 SHALL have port wdt_kick, input, 1 bit: watchdog service strobe.
REQ-011 SHALL have port locked, input, 1 bit: asynchronous PLL lock status.
REQ-012 SHALL have port rstn_req, output, 1 bit: active-low reset request to the downstream reset controller's rstn input.
REQ-013 SHALL have port rst_cause, output, 3 bits: cause of the most recent accepted event.
REQ-014 SHALL have port busy, output, 1 bit: high while in ASSERT or HOLDOFF.

Function
REQ-015 SHALL synchronize btn_n and locked, each through a 2-flop synchronizer, before any use.
REQ-016 SHALL raise a button event once, when the synchronized btn_n has been low for DEBOUNCE_CYCLES consecutive cycles.
- Any high sample SHALL restart the count.
- No new button event SHALL occur until btn_n has been high for DEBOUNCE_CYCLES.
REQ-017 SHALL raise a software event in any cycle in which sw_rst_req=1.
REQ-018 SHALL run a 32-bit watchdog counter:
- Clears to 0 when wdt_en=0, when wdt_kick=1, or in any state other than IDLE.
- Otherwise increments by 1 per cycle.
- Raises a watchdog event when the count equals WDT_CYCLES-1, then clears.
REQ-019 SHALL raise a lock event on a 1->0 transition of the synchronized locked.
REQ-020 SHALL implement an FSM with states IDLE, ASSERT and HOLDOFF.
REQ-021 In IDLE, an event in cycle N SHALL move the FSM to ASSERT, drive rstn_req=0 from cycle N+1, and latch rst_cause.
REQ-022 When events coincide, SHALL apply priority button(1) > software(2) > watchdog(3) > lock(4); rst_cause=0 means no event since reset.
REQ-023 SHALL hold rstn_req=0 for exactly PULSE_CYCLES cycles, then go to HOLDOFF with rstn_req=1.
REQ-024 SHALL stay in HOLDOFF for exactly HOLDOFF_CYCLES cycles, then return to IDLE.
REQ-025 SHALL discard all events raised in ASSERT or HOLDOFF; no queueing.
REQ-026 SHALL keep rst_cause unchanged until the next accepted event.
REQ-027 SHALL treat PULSE_CYCLES=0 as 1 and HOLDOFF_CYCLES=0 as 0, meaning ASSERT goes directly to IDLE.

Reset
REQ-028 While rst=1, SHALL drive rstn_req=1, rst_cause=0 and busy=0, and hold the FSM in IDLE with all counters cleared; rst does not itself produce a request pulse.
REQ-029 On rst assertion mid-pulse, SHALL immediately (asynchronously) release rstn_req to 1.
REQ-030 SHALL initialize synchronizer flops to the inactive level (btn_n=1, locked=1), so that reset release does not create a false event.

Structure
REQ-031 SHALL place the FSM state enum and the rst_cause enum (NONE=0, BTN=1, SW=2, WDT=3, LOCK=4) in shared package reset_pkg.
REQ-032 SHALL implement synchronizer plus debounce as one sub-module, debounce, instantiated for btn_n; locked uses its synchronizer only.

Verification
REQ-033 Bench parameters SHALL be DEBOUNCE_CYCLES=4, WDT_CYCLES=16, PULSE_CYCLES=8, HOLDOFF_CYCLES=4.
REQ-034 sw_rst_req=1 for 1 cycle at cycle N -> rstn_req=0 for cycles N+1..N+8; busy=1 for cycles N+1..N+12; rst_cause=2.
REQ-035 btn_n low with 2-cycle glitches, then low steadily for 10 cycles -> exactly one pulse, rst_cause=1; a 3-cycle-low glitch alone -> no pulse.
REQ-036 wdt_en=1, no kicks -> pulse starting 17 cycles after enable, rst_cause=3; kick every 10 cycles -> no pulse over 200 cycles.
REQ-037 sw_rst_req and a debounced button event in the same cycle -> a single pulse, rst_cause=1; sw_rst_req during HOLDOFF -> ignored, and no pulse follows.
REQ-038 locked 1->0 -> pulse with rst_cause=4; rst asserted at pulse cycle 3 -> rstn_req=1 the same cycle, rst_cause=0, and no pulse resumes after release.
